adc_avg: RTL and testbench

- Downstream consumer of the DAC/SAR multiplexer's conversion reports.
- Per channel, accumulates 1/2/4/8 successive 10-bit SAR results and produces a rounded average.
- Checks each completed average against a global high/low window and raises sticky per-channel status plus an interrupt.
- Averages are readable through a channel-indexed read port for the SFR/REGX read mux.

---
 rtl/adc_avg.sv | 160 ++++++++++++++++
 tb/tb_adc_avg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg.sv
// rtl/adc_avg.sv - per-channel SAR averager with window status; `define ADC_AVG_PEAK_EN adds peak hold
module adc_avg #(
  parameter int BIT_PTR = 4,
  parameter int N_CH    = 16
) (
  input  logic               clk,
  input  logic               srstz,
  input  logic               i_rpt,
  input  logic [BIT_PTR-1:0] i_ch,
  input  logic [9:0]         i_val,
  input  logic [7:0]         r_wdat,
  input  logic [6:0]         r_wr,
  input  logic [BIT_PTR-1:0] i_rd_ch,
`ifdef ADC_AVG_PEAK_EN
  input  logic               i_rd_pk,
`endif
  output logic [9:0]         o_rd_val,
  output logic               o_vld,
  output logic [BIT_PTR-1:0] o_vch,
  output logic [7:0]         o_avgctl,
  output logic [N_CH-1:0]    o_sta,
  output logic               o_intr
);

  localparam logic [BIT_PTR:0] NCH_W = (BIT_PTR+1)'(N_CH);

  logic              en;
  logic [1:0]        sel;
  logic [7:0]        hithr;
  logic [7:0]        lothr;
  logic [N_CH-1:0]   winen;
  logic [N_CH-1:0]   sta;
  logic              vld;
  logic [BIT_PTR-1:0] vch;

  logic [12:0] acc [N_CH];
  logic [2:0]  cnt [N_CH];
  logic [9:0]  avg [N_CH];
`ifdef ADC_AVG_PEAK_EN
  logic [9:0]  peak [N_CH];
`endif

  logic        ch_ok;
  logic        rd_ok;
  logic        accept;
  logic        done;
  logic [12:0] cur_acc;
  logic [2:0]  cur_cnt;
  logic [2:0]  last_idx;
  logic [2:0]  rnd;
  logic [13:0] sum;
  logic [9:0]  avg_new;
  logic        win_ch;
  logic        out_win;
  logic [N_CH-1:0] sta_set;
  logic [15:0] clr16;
  logic [15:0] winen16;
  logic [15:0] winen_nxt;

  assign ch_ok   = ({1'b0, i_ch} < NCH_W);
  assign rd_ok   = ({1'b0, i_rd_ch} < NCH_W);
  // an AVGCTL write in the same cycle takes priority and drops the sample
  assign accept  = i_rpt & en & ch_ok & ~r_wr[0];
  assign cur_acc = ch_ok ? acc[i_ch] : '0;
  assign cur_cnt = ch_ok ? cnt[i_ch] : '0;
  assign win_ch  = ch_ok ? winen[i_ch] : 1'b0;

  // sample count minus one and rounding constant for the selected average length
  always_comb begin
    last_idx = 3'd0;
    rnd      = 3'd0;
    case (sel)
      2'd1:    begin last_idx = 3'd1; rnd = 3'd1; end
      2'd2:    begin last_idx = 3'd3; rnd = 3'd2; end
      2'd3:    begin last_idx = 3'd7; rnd = 3'd4; end
      default: begin last_idx = 3'd0; rnd = 3'd0; end
    endcase
  end

  assign done    = accept & (cur_cnt == last_idx);
  assign sum     = 14'(cur_acc) + 14'(i_val) + 14'(rnd);
  assign avg_new = 10'(sum >> sel);
  assign out_win = win_ch & ((avg_new[9:2] > hithr) | (avg_new[9:2] < lothr));
  assign sta_set = (done & out_win) ? (N_CH'(1) << i_ch) : '0;

  assign clr16     = {r_wr[2] ? r_wdat : 8'h00, r_wr[1] ? r_wdat : 8'h00};
  assign winen16   = 16'(winen);
  assign winen_nxt = {r_wr[6] ? r_wdat : winen16[15:8], r_wr[5] ? r_wdat : winen16[7:0]};

  // control, threshold, window-enable and sticky status registers
  always_ff @(posedge clk) begin
    if (!srstz) begin
      en    <= 1'b0;
      sel   <= 2'd0;
      hithr <= 8'hff;
      lothr <= 8'h00;
      winen <= '0;
      sta   <= '0;
      vld   <= 1'b0;
      vch   <= '0;
    end else begin
      if (r_wr[0]) begin
        en  <= r_wdat[7];
        sel <= r_wdat[1:0];
      end
      if (r_wr[3]) hithr <= r_wdat;
      if (r_wr[4]) lothr <= r_wdat;
      winen <= winen_nxt[N_CH-1:0];
      sta   <= (sta & ~clr16[N_CH-1:0]) | sta_set;
      vld   <= done;
      if (done) vch <= i_ch;
    end
  end

  // per-channel accumulation and average/peak update
  always_ff @(posedge clk) begin
    if (!srstz) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        avg[i] <= '0;
`ifdef ADC_AVG_PEAK_EN
        peak[i] <= '0;
`endif
      end
    end else if (r_wr[0]) begin
      for (int i = 0; i < N_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
`ifdef ADC_AVG_PEAK_EN
        if (r_wdat[6]) peak[i] <= '0;
`endif
      end
    end else if (accept) begin
      if (done) begin
        avg[i_ch] <= avg_new;
        acc[i_ch] <= '0;
        cnt[i_ch] <= '0;
`ifdef ADC_AVG_PEAK_EN
        if (avg_new > peak[i_ch]) peak[i_ch] <= avg_new;
`endif
      end else begin
        acc[i_ch] <= cur_acc + 13'(i_val);
        cnt[i_ch] <= cur_cnt + 3'd1;
      end
    end
  end

`ifdef ADC_AVG_PEAK_EN
  assign o_rd_val = rd_ok ? (i_rd_pk ? peak[i_rd_ch] : avg[i_rd_ch]) : 10'd0;
`else
  assign o_rd_val = rd_ok ? avg[i_rd_ch] : 10'd0;
`endif
  assign o_vld    = vld;
  assign o_vch    = vch;
  assign o_avgctl = {en, 5'b0, sel};
  assign o_sta    = sta;
  assign o_intr   = |sta;

endmodule

// File: tb/tb_adc_avg.sv
// tb/tb_adc_avg.sv - scoreboard bench for adc_avg with a behavioural averaging model
module tb_adc_avg;
  localparam int BP  = 4;
  localparam int NCH = 12;

  logic           clk = 1'b0;
  logic           srstz;
  logic           i_rpt;
  logic [BP-1:0]  i_ch;
  logic [9:0]     i_val;
  logic [7:0]     r_wdat;
  logic [6:0]     r_wr;
  logic [BP-1:0]  i_rd_ch;
`ifdef ADC_AVG_PEAK_EN
  logic           i_rd_pk = 1'b0;
`endif
  logic [9:0]     o_rd_val;
  logic           o_vld;
  logic [BP-1:0]  o_vch;
  logic [7:0]     o_avgctl;
  logic [NCH-1:0] o_sta;
  logic           o_intr;

  always #5 clk = ~clk;

  adc_avg #(.BIT_PTR(BP), .N_CH(NCH)) dut (
    .clk(clk), .srstz(srstz), .i_rpt(i_rpt), .i_ch(i_ch), .i_val(i_val),
    .r_wdat(r_wdat), .r_wr(r_wr), .i_rd_ch(i_rd_ch),
`ifdef ADC_AVG_PEAK_EN
    .i_rd_pk(i_rd_pk),
`endif
    .o_rd_val(o_rd_val), .o_vld(o_vld), .o_vch(o_vch), .o_avgctl(o_avgctl),
    .o_sta(o_sta), .o_intr(o_intr)
  );

  typedef struct { int ch; int val; } exp_t;
  exp_t expq[$];
  exp_t e;

  int m_en, m_sel, m_hi, m_lo;
  logic [NCH-1:0] m_win, m_sta;
  int m_sum[NCH];
  int m_cnt[NCH];
  int m_avg[NCH];
  int n_checks = 0;
  int n_fail = 0;
  int vld_seen = 0;
  int prev_ch = 0;
  int base;
  bit mon_en = 0;

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_init();
    m_en = 0; m_sel = 0; m_hi = 255; m_lo = 0; m_win = '0; m_sta = '0;
    for (int i = 0; i < NCH; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_avg[i] = 0;
    end
    expq.delete();
  endtask

  // one clock cycle of stimulus; model applies the same cycle's effects after the edge
  task automatic cyc(bit rpt, int ch, int val, logic [6:0] wr, logic [7:0] wd);
    logic [NCH-1:0] set_m;
    logic [NCH-1:0] clr_m;
    int n, a;
    i_rpt = rpt; i_ch = BP'(ch); i_val = 10'(val); r_wr = wr; r_wdat = wd;
    i_rd_ch = BP'(prev_ch);
    @(posedge clk);
    set_m = '0; clr_m = '0;
    if (wr[0]) begin
      m_en = int'(wd[7]); m_sel = int'(wd[1:0]);
      for (int i = 0; i < NCH; i++) begin m_sum[i] = 0; m_cnt[i] = 0; end
    end else if (rpt && m_en == 1 && ch < NCH) begin
      n = 1 << m_sel;
      m_sum[ch] += val;
      m_cnt[ch] += 1;
      if (m_cnt[ch] == n) begin
        a = (m_sum[ch] + n / 2) / n;
        m_avg[ch] = a;
        expq.push_back('{ch, a});
        if (m_win[ch] && ((a / 4) > m_hi || (a / 4) < m_lo)) set_m[ch] = 1'b1;
        m_sum[ch] = 0; m_cnt[ch] = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (i < 8 && wr[1] && wd[i % 8]) clr_m[i] = 1'b1;
      if (i >= 8 && wr[2] && wd[i % 8]) clr_m[i] = 1'b1;
    end
    m_sta = (m_sta & ~clr_m) | set_m;
    if (wr[3]) m_hi = int'(wd);
    if (wr[4]) m_lo = int'(wd);
    for (int i = 0; i < NCH; i++) begin
      if (i < 8 && wr[5]) m_win[i] = wd[i % 8];
      if (i >= 8 && wr[6]) m_win[i] = wd[i % 8];
    end
    prev_ch = ch;
    #1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 7'h00, 8'h00);
  endtask

  task automatic do_reset();
    mon_en = 0;
    srstz = 1'b0;
    i_rpt = 0; i_ch = '0; i_val = '0; r_wr = '0; r_wdat = '0; i_rd_ch = '0;
    @(posedge clk); #1;
    srstz = 1'b1;
    model_init();
    prev_ch = 0;
    mon_en = 1;
  endtask

  task automatic chk_regs(string tag);
    chk({tag, "_sta"}, int'(o_sta), int'(m_sta));
    chk({tag, "_intr"}, int'(o_intr), int'(|m_sta));
    chk({tag, "_avgctl"}, int'(o_avgctl), (m_en << 7) | m_sel);
  endtask

  task automatic rd_all(string tag);
    for (int i = 0; i < NCH; i++) begin
      i_rd_ch = BP'(i);
      @(negedge clk);
      chk({tag, "_rd"}, int'(o_rd_val), m_avg[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic rd_one(string name, int ch, int expv);
    i_rd_ch = BP'(ch);
    @(negedge clk);
    chk(name, int'(o_rd_val), expv);
    @(posedge clk); #1;
  endtask

  // monitor: every o_vld pulse must match the oldest expected average
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && o_vld) begin
        vld_seen++;
        if (expq.size() == 0) begin
          chk("unexpected_vld", int'(o_vld), 0);
        end else begin
          e = expq.pop_front();
          chk("vld_ch", int'(o_vch), e.ch);
          chk("vld_avg", int'(o_rd_val), e.val);
        end
      end
    end
  end

  initial begin
    srstz = 1'b0;
    i_rpt = 0; i_ch = '0; i_val = '0; r_wr = '0; r_wdat = '0; i_rd_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    chk("rst_avgctl", int'(o_avgctl), 0);
    chk("rst_sta", int'(o_sta), 0);
    chk("rst_intr", int'(o_intr), 0);
    chk("rst_vld", int'(o_vld), 0);
    rd_all("rst");

    cyc(0, 0, 0, 7'h01, 8'h82);
    chk("avgctl_82", int'(o_avgctl), 8'h82);
    base = vld_seen;
    for (int k = 0; k < 4; k++) cyc(1, 3, 100 + k, 7'h00, 8'h00);
    idle(3);
    chk("avg4_vld_count", vld_seen - base, 1);
    rd_one("avg4_ch3", 3, 102);

    cyc(0, 0, 0, 7'h01, 8'h83);
    base = vld_seen;
    for (int k = 0; k < 16; k++) cyc(1, k % 2, (k % 2) ? 1 : 1023, 7'h00, 8'h00);
    idle(3);
    chk("b2b_vld_count", vld_seen - base, 2);
    rd_one("b2b_ch0", 0, 1023);
    rd_one("b2b_ch1", 1, 1);

    cyc(0, 0, 0, 7'h20, 8'h20);
    cyc(0, 0, 0, 7'h08, 8'h80);
    cyc(0, 0, 0, 7'h01, 8'h80);
    cyc(1, 5, 10'h204, 7'h00, 8'h00);
    idle(1);
    chk("win_sta5", int'(o_sta[5]), 1);
    chk_regs("win");
    cyc(1, 5, 10'h204, 7'h02, 8'h20);
    idle(1);
    chk("setbeatsclr_sta5", int'(o_sta[5]), 1);
    cyc(0, 0, 0, 7'h02, 8'h20);
    chk("w1c_sta", int'(o_sta), 0);
    cyc(0, 0, 0, 7'h08, 8'h10);
    cyc(0, 0, 0, 7'h10, 8'h90);
    cyc(1, 5, 10'h150, 7'h00, 8'h00);
    cyc(0, 0, 0, 7'h04, 8'hff);
    chk("inverted_thr_sta5", int'(o_sta[5]), 1);
    chk_regs("inv");
    cyc(0, 0, 0, 7'h02, 8'hff);

    cyc(0, 0, 0, 7'h01, 8'h83);
    for (int k = 0; k < 3; k++) cyc(1, 2, 1000, 7'h00, 8'h00);
    cyc(0, 0, 0, 7'h01, 8'h83);
    for (int k = 0; k < 8; k++) cyc(1, 2, 500, 7'h00, 8'h00);
    idle(2);
    rd_one("discard_ch2", 2, 500);

    base = vld_seen;
    cyc(0, 0, 0, 7'h01, 8'h03);
    for (int k = 0; k < 8; k++) cyc(1, k % NCH, 77, 7'h00, 8'h00);
    cyc(0, 0, 0, 7'h01, 8'h80);
    for (int k = 0; k < 4; k++) cyc(1, 15 - k, 300, 7'h00, 8'h00);
    idle(2);
    chk("ignored_vld_count", vld_seen - base, 0);
    rd_all("ignored");

    cyc(0, 0, 0, 7'h01, 8'h82);
    cyc(1, 4, 1000, 7'h00, 8'h00);
    cyc(1, 4, 1000, 7'h00, 8'h00);
    idle(1);
    do_reset();
    rd_all("midrst");
    cyc(0, 0, 0, 7'h01, 8'h82);
    for (int k = 0; k < 4; k++) cyc(1, 4, 8, 7'h00, 8'h00);
    idle(2);
    rd_one("midrst_ch4", 4, 8);

    for (int k = 0; k < 600; k++) begin
      int r;
      logic [6:0] wr;
      logic [7:0] wd;
      r = $urandom_range(0, 99);
      wr = 7'h00;
      wd = 8'($urandom);
      if (r < 2) begin
        wr = 7'h01;
        wd[7] = ($urandom_range(0, 7) != 0);
      end else if (r < 7) begin
        wr = 7'(1 << $urandom_range(3, 6));
      end else if (r < 12) begin
        wr = 7'(1 << $urandom_range(1, 2));
      end
      cyc(($urandom_range(0, 9) < 8), $urandom_range(0, 15), $urandom_range(0, 1023), wr, wd);
      chk_regs("rand");
    end
    idle(3);
    rd_all("final");
    chk("queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
